// File: rtl/srlatch_bank_ctrl.sv
// srlatch_bank_ctrl: arbitrates set/reset requests and pulses one SR latch of a bank at a time.
// Optional readback checking of latch feedback is enabled by SRLATCH_BANK_CTRL_READBACK_EN.
module srlatch_bank_ctrl #(
  parameter int N     = 4,
  parameter int PULSE = 3,
  parameter int GAP   = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 set_req,
  input  logic [$clog2(N)-1:0] set_idx,
  output logic                 set_ack,
  input  logic                 rst_req,
  input  logic [$clog2(N)-1:0] rst_idx,
  output logic                 rst_ack,
  output logic [N-1:0]         S,
  output logic [N-1:0]         R,
  output logic                 busy
`ifdef SRLATCH_BANK_CTRL_READBACK_EN
  ,
  input  logic [N-1:0]         Q,
  output logic                 err
`endif
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(PULSE + GAP + 2);
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_DRIVE, ST_GAP} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic op, op_n, own, own_n, rr, rr_n, last_gap;
  logic [N-1:0] one_hot, s_n, r_n;
  // op = 1 means set; rr = 1 means a contested grant goes to the reset requester
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    idx_n = idx;
    op_n  = op;
    own_n = own;
    rr_n  = rr;
    case (st)
      ST_INIT: begin
        st_n  = (cnt == CW'(PULSE)) ? ST_GAP : ST_INIT;
        cnt_n = (cnt == CW'(PULSE)) ? '0 : cnt + CW'(1);
        own_n = 1'b0;
      end
      ST_IDLE: if (set_req || rst_req) begin
        st_n  = ST_DRIVE;
        cnt_n = '0;
        own_n = 1'b1;
        op_n  = set_req && !(rst_req && rr);
        idx_n = op_n ? set_idx : rst_idx;
        rr_n  = (set_req && rst_req) ? !rr : rr;
      end
      ST_DRIVE: begin
        st_n  = (cnt == CW'(PULSE - 1)) ? ST_GAP : ST_DRIVE;
        cnt_n = (cnt == CW'(PULSE - 1)) ? '0 : cnt + CW'(1);
      end
      default: begin
        st_n  = (cnt == CW'(GAP - 1)) ? ST_IDLE : ST_GAP;
        cnt_n = (cnt == CW'(GAP - 1)) ? '0 : cnt + CW'(1);
        own_n = (cnt == CW'(GAP - 1)) ? 1'b0 : own;
      end
    endcase
    // outputs are registered from the next state so they line up with it
    last_gap = (st_n == ST_GAP) && (cnt_n == CW'(GAP - 1));
    one_hot  = N'(1) << idx_n;
    s_n      = (st_n == ST_DRIVE && op_n) ? one_hot : '0;
    r_n      = (st_n == ST_INIT && cnt_n != '0) ? '1 :
               (st_n == ST_DRIVE && !op_n) ? one_hot : '0;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st      <= ST_INIT;
      cnt     <= '0;
      idx     <= '0;
      op      <= 1'b0;
      own     <= 1'b0;
      rr      <= 1'b1;
      S       <= '0;
      R       <= '0;
      set_ack <= 1'b0;
      rst_ack <= 1'b0;
      busy    <= 1'b1;
`ifdef SRLATCH_BANK_CTRL_READBACK_EN
      err     <= 1'b0;
`endif
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      op      <= op_n;
      own     <= own_n;
      rr      <= rr_n;
      S       <= s_n;
      R       <= r_n;
      set_ack <= last_gap && own_n && op_n;
      rst_ack <= last_gap && own_n && !op_n;
      busy    <= st_n != ST_IDLE;
`ifdef SRLATCH_BANK_CTRL_READBACK_EN
      err     <= err | (last_gap && (own_n ? (Q[idx_n] != op_n) : (Q != '0)));
`endif
    end
  end
endmodule

// File: tb/tb_srlatch_bank_ctrl.sv
// tb_srlatch_bank_ctrl: directed stimulus with a per-cycle expected-frame scoreboard.
module tb_srlatch_bank_ctrl;
  logic CLK = 1'b0, RESET = 1'b1;
  logic set_req = 1'b0, rst_req = 1'b0;
  logic [1:0] set_idx = '0, rst_idx = '0;
  logic set_ack, rst_ack, busy, err_o;
  logic [3:0] S, R, Q;
  logic [3:0] q_m = '0;
  logic q_stuck = 1'b0;
  int cyc = 0, checks = 0, passes = 0;
  typedef struct {
    int c;
    string nm;
    logic [3:0] s, r;
    logic b, sa, ra, e;
  } frame_t;
  frame_t exq[$];
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // behavioural latch bank fed by the controller, with a stuck-at-zero option
  always @(posedge CLK) q_m <= (q_m | S) & ~R;
  assign Q = q_stuck ? 4'b0 : q_m;

  srlatch_bank_ctrl #(.N(4), .PULSE(3), .GAP(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .set_req(set_req), .set_idx(set_idx), .set_ack(set_ack),
    .rst_req(rst_req), .rst_idx(rst_idx), .rst_ack(rst_ack),
    .S(S), .R(R), .busy(busy)
`ifdef SRLATCH_BANK_CTRL_READBACK_EN
    , .Q(Q), .err(err_o)
`endif
  );
`ifndef SRLATCH_BANK_CTRL_READBACK_EN
  assign err_o = 1'b0;
`endif

  task automatic exp(input int c, input string nm, input logic [3:0] s, input logic [3:0] r,
                     input logic b, input logic sa, input logic ra, input logic e);
    frame_t f;
    f.c = c; f.nm = nm; f.s = s; f.r = r; f.b = b; f.sa = sa; f.ra = ra; f.e = e;
    exq.push_back(f);
  endtask

  task automatic push_op(input int k, input string nm, input logic set, input int idx,
                         input logic e0, input logic e1);
    logic [3:0] oh;
    oh = 4'(1) << idx;
    for (int i = 0; i < 3; i++) exp(k + i, nm, set ? oh : 4'b0, set ? 4'b0 : oh, 1'b1, 1'b0, 1'b0, e0);
    exp(k + 3, {nm, "_ack"}, 4'b0, 4'b0, 1'b1, set, !set, e1);
  endtask

  task automatic push_idle(input int c, input string nm, input logic e);
    exp(c, nm, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic push_init(input int c0, input string nm);
    for (int i = 1; i <= 3; i++) exp(c0 + i, nm, 4'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    exp(c0 + 4, {nm, "_gap"}, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_idle(c0 + 5, {nm, "_idle"}, 1'b0);
  endtask

  task automatic step();
    @(negedge CLK);
    #2;
  endtask

  always @(negedge CLK) begin
    frame_t f;
    logic [11:0] got, want;
    while (exq.size() > 0 && exq[0].c < cyc) begin
      checks++;
      $display("FAIL %s: expected frame for cycle %0d was never compared", exq[0].nm, exq[0].c);
      void'(exq.pop_front());
    end
    got = {S, R, busy, set_ack, rst_ack, err_o};
    if (exq.size() > 0 && exq[0].c == cyc) begin
      f = exq.pop_front();
      want = {f.s, f.r, f.b, f.sa, f.ra, f.e};
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s cycle %0d: got S,R,busy,sack,rack,err=%b required %b", f.nm, cyc, got, want);
    end else if (set_ack || rst_ack) begin
      checks++;
      $display("FAIL unexpected_ack cycle %0d: got sack=%b rack=%b required 0 0", cyc, set_ack, rst_ack);
    end
    if ((S & R) != 4'b0) begin
      checks++;
      $display("FAIL s_r_overlap cycle %0d: got S=%b R=%b required disjoint", cyc, S, R);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k, c;
    step();
    step();
    exp(cyc + 1, "reset_hold", 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    RESET = 1'b0;
    push_init(cyc, "init");
    repeat (5) step();

    set_req = 1'b1; set_idx = 2'd2; k = cyc + 1;
    push_op(k, "set2", 1'b1, 2, 1'b0, 1'b0);
    push_idle(k + 4, "set2_done", 1'b0);
    repeat (4) step();
    set_req = 1'b0;
    step();

    set_req = 1'b1; rst_req = 1'b1; set_idx = 2'd1; rst_idx = 2'd1; k = cyc + 1;
    push_op(k, "contest_rst", 1'b0, 1, 1'b0, 1'b0);
    push_idle(k + 4, "contest_mid", 1'b0);
    push_op(k + 5, "contest_set", 1'b1, 1, 1'b0, 1'b0);
    push_idle(k + 9, "contest_done", 1'b0);
    repeat (4) step();
    rst_req = 1'b0;
    repeat (5) step();
    set_req = 1'b0;
    step();

    set_req = 1'b1; set_idx = 2'd0; k = cyc + 1;
    exp(k, "abort_drive", 4'b0001, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp(k + 1, "abort_drive2", 4'b0001, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    RESET = 1'b1; set_req = 1'b0;
    #1;
    checks++;
    if ({S, R, busy, set_ack, rst_ack} === {4'b0, 4'b0, 1'b1, 1'b0, 1'b0}) passes++;
    else $display("FAIL async_reset: got S=%b R=%b busy=%b acks=%b%b required 0000 0000 1 00",
                  S, R, busy, set_ack, rst_ack);
    exp(k + 2, "abort_hold", 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    RESET = 1'b0;
    push_init(cyc, "reinit");
    repeat (5) step();

    set_req = 1'b1; rst_req = 1'b1; set_idx = 2'd3; rst_idx = 2'd2; k = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      push_op(k + 5 * i, (i % 2) ? "alt_set" : "alt_rst", (i % 2) == 1, (i % 2) ? 3 : 2, 1'b0, 1'b0);
      push_idle(k + 5 * i + 4, "alt_idle", 1'b0);
    end
    repeat (39) step();
    set_req = 1'b0; rst_req = 1'b0;
    step();

`ifdef SRLATCH_BANK_CTRL_READBACK_EN
    q_stuck = 1'b1; set_req = 1'b1; set_idx = 2'd3; k = cyc + 1;
    push_op(k, "rb_set", 1'b1, 3, 1'b0, 1'b1);
    push_idle(k + 4, "rb_hold", 1'b1);
    repeat (4) step();
    set_req = 1'b0;
    step();
    push_idle(cyc + 3, "rb_sticky", 1'b1);
    q_stuck = 1'b0;
    repeat (3) step();
    RESET = 1'b1;
    exp(cyc + 1, "rb_clear", 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    RESET = 1'b0;
    push_init(cyc, "rb_init");
    repeat (5) step();
`endif

    repeat (2) step();
    while (exq.size() > 0) begin
      checks++;
      $display("FAIL %s: expected frame for cycle %0d left unchecked", exq[0].nm, exq[0].c);
      void'(exq.pop_front());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/srlatch_bank_ctrl.md
SRLATCH_BANK_CTRL -- requirements
Module: srlatch_bank_ctrl

Interface
REQ-001 Parameters SHALL be: N, 4, number of SR latches in bank (2..16); PULSE, 3, cycles S or R held active (>=1); GAP, 1, cycles all-low after each pulse (>=1).
REQ-002 Ports SHALL be (name direction width meaning):
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- set_req  in  1  set requester request.
- set_idx  in  clog2(N)  latch index to set.
- set_ack  out  1  one-cycle set completion.
- rst_req  in  1  reset requester request.
- rst_idx  in  clog2(N)  latch index to reset.
- rst_ack  out  1  one-cycle reset completion.
- S  out  N  latch set drives.
- R  out  N  latch reset drives.
- busy  out  1  high whenever state is not IDLE.
- Q  in  N  latch feedback (only with SRLATCH_BANK_CTRL_READBACK_EN).
- err  out  1  sticky readback error (only with SRLATCH_BANK_CTRL_READBACK_EN).
REQ-003 One clock domain; all outputs SHALL be registered.

Function
REQ-004 States SHALL be INIT, IDLE, DRIVE, GAP.
REQ-005 INIT: R = all ones, S = 0, for PULSE cycles, then GAP; clears all latches out of unknown state.
REQ-006 IDLE: requests sampled each edge; no request -> stay IDLE, S = R = 0.
REQ-007 Only one request high -> grant it; store idx and op (set/reset); go DRIVE.
REQ-008 Both high -> grant per round-robin bit (post-reset favours reset requester); bit toggles after each contested grant; loser stays pending.
REQ-009 DRIVE: exactly one bit asserted, S[idx] (set) or R[idx] (reset), for PULSE cycles; then GAP.
REQ-010 GAP: S = R = 0 for GAP cycles; granted ack SHALL be high during the final GAP cycle only; then IDLE (INIT-originated GAP returns to IDLE with no ack).
REQ-011 Latency: req high at edge k -> drive cycles k+1..k+PULSE, ack at cycle k+PULSE+GAP, next grant sampled at edge k+PULSE+GAP+1.
REQ-012 Invariant: S & R == 0 at all times; popcount(S|R) <= 1 outside INIT.
REQ-013 Requester SHALL hold req and idx stable until ack; req still high the cycle after ack is a new request.
REQ-014 idx/req changes during DRIVE/GAP SHALL not affect the operation in progress.
REQ-015 Set and reset of the same idx contested -> served sequentially, final latch state follows second grant.

Reset
REQ-016 RESET high SHALL immediately force S = 0, R = 0, set_ack = rst_ack = 0, busy = 1, state INIT, pulse counter 0, round-robin favouring reset, err = 0.
REQ-017 RESET asserted mid-DRIVE/GAP SHALL abort the operation with no ack; INIT runs after release.

Configuration
REQ-018 Macro SRLATCH_BANK_CTRL_READBACK_EN defined: Q and err ports exist; in final GAP cycle Q[idx] compared to expected (1 set, 0 reset), after INIT Q compared to all zeros; mismatch sets err, held until RESET.
REQ-019 Macro undefined: no Q or err ports, no comparison logic; all other behaviour identical.

Verification
REQ-020 Bench SHALL cover (N=4, PULSE=3, GAP=1):
- Release RESET -> R=4'b1111 cycles 1-3, cycle 4 all zero, busy low from cycle 5, no acks.
- set_req, set_idx=2 at edge k -> S=4'b0100 cycles k+1..k+3, set_ack=1 cycle k+4 only, R=0 throughout.
- set_req idx 1 and rst_req idx 1 same edge after reset -> reset served first, rst_ack, then set, set_ack; S&R never both nonzero.
- RESET pulsed during second DRIVE cycle -> S/R zero asynchronously, no ack, INIT sequence repeats.
- READBACK_EN, Q held 0 during set of idx 3 -> err=1 from ack cycle, stays 1 until RESET.
- Continuous both requests for 8 grants -> strict alternation reset/set.
